// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter that shares one shift-add multiplier (WIDTH x WIDTH) among NREQ requesters.
// Optional macro MULT_EARLY_DONE_EN: finish as soon as the remaining multiplier bits are all zero.
module mult_share_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_mcd,
    input  logic [NREQ*WIDTH-1:0]   req_mlt,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [2*WIDTH-1:0]      res_prod,
    output logic [IDW-1:0]          res_id,
    output logic                    busy
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e             state_q, state_d;
    logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]     id_q, id_d;
    logic [IDW-1:0]     res_id_q, res_id_d;
    logic [CW-1:0]      count_q, count_d;
    logic [2*WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   mcd_q, mcd_d;
    logic [2*WIDTH-1:0] res_prod_q, res_prod_d;

    logic               found;
    logic [IDW-1:0]     win;
    logic [IDW-1:0]     idx;
    logic [WIDTH:0]     add_v;
    logic [2*WIDTH:0]   step;
    logic [2*WIDTH:0]   fin;
    logic               last;

    // Round-robin search starting at rr_ptr; first valid requester wins.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = IDW'((int'(rr_ptr_q) + i) % NREQ);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // acc[2W] is always zero at the start of a step, so the W+1-bit add cannot overflow.
    always_comb begin
        add_v = acc_q[2*WIDTH:WIDTH];
        if (acc_q[0])
            add_v = acc_q[2*WIDTH:WIDTH] + {1'b0, mcd_q};
        step = {add_v, acc_q[WIDTH-1:0]} >> 1;
    end

`ifdef MULT_EARLY_DONE_EN
    logic [WIDTH-1:0] rem_mask;
    always_comb begin
        rem_mask = {WIDTH{1'b1}} >> (int'(count_q) + 1);
        last     = ((step[WIDTH-1:0] & rem_mask) == '0);
        fin      = step >> (WIDTH - 1 - int'(count_q));
    end
`else
    always_comb begin
        last = (count_q == CW'(WIDTH - 1));
        fin  = step;
    end
`endif

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        id_d       = id_q;
        count_d    = count_q;
        acc_d      = acc_q;
        mcd_d      = mcd_q;
        res_prod_d = res_prod_q;
        res_id_d   = res_id_q;
        req_ready  = '0;
        case (state_q)
            IDLE: begin
                if (found && rst_n) begin
                    req_ready[win] = 1'b1;
                    acc_d          = {{(WIDTH+1){1'b0}}, req_mlt[int'(win)*WIDTH +: WIDTH]};
                    mcd_d          = req_mcd[int'(win)*WIDTH +: WIDTH];
                    id_d           = win;
                    rr_ptr_d       = IDW'((int'(win) + 1) % NREQ);
                    count_d        = '0;
                    state_d        = RUN;
                end
            end
            RUN: begin
                acc_d   = step;
                count_d = count_q + 1'b1;
                if (last) begin
                    acc_d      = fin;
                    res_prod_d = fin[2*WIDTH-1:0];
                    res_id_d   = id_q;
                    state_d    = DONE;
                end
            end
            DONE: begin
                if (res_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            id_q       <= '0;
            count_q    <= '0;
            acc_q      <= '0;
            mcd_q      <= '0;
            res_prod_q <= '0;
            res_id_q   <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so all flops update together.
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            id_q       <= id_d;
            count_q    <= count_d;
            acc_q      <= acc_d;
            mcd_q      <= mcd_d;
            res_prod_q <= res_prod_d;
            res_id_q   <= res_id_d;
        end
    end

    assign res_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign res_prod  = res_prod_q;
    assign res_id    = res_id_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Self-checking bench for mult_share_arbiter: scoreboard of expected products pushed at grant,
// popped and compared when a result is handed off.
module tb_mult_share_arbiter;

    localparam int N = 4;
    localparam int W = 8;
    localparam int I = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_mcd;
    logic [N*W-1:0]   req_mlt;
    logic             res_valid;
    logic             res_ready;
    logic [2*W-1:0]   res_prod;
    logic [I-1:0]     res_id;
    logic             busy;

    mult_share_arbiter #(.NREQ(N), .WIDTH(W), .IDW(I)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_mcd   (req_mcd),
        .req_mlt   (req_mlt),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_prod  (res_prod),
        .res_id    (res_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        int prod;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   grant_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   last_lat = 0;
    int   valid_seen = 0;
    logic prev_valid = 1'b0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (rst_n) begin
            for (int k = 0; k < N; k++) begin
                if (req_ready[k] && req_valid[k]) begin
                    e.id   = k;
                    e.prod = int'(req_mcd[k*W +: W]) * int'(req_mlt[k*W +: W]);
                    e.cyc  = cyc;
                    sb.push_back(e);
                    grant_q.push_back(k);
                end
            end
            if (res_valid && !prev_valid) begin
                if (sb.size() == 0) begin
                    check("orphan_result", 32'd1, 32'd0);
                end else begin
                    last_lat = cyc - sb[0].cyc;
`ifdef MULT_EARLY_DONE_EN
                    check("latency_range", 32'(last_lat >= 2 && last_lat <= W + 1), 32'd1);
`else
                    check("latency", 32'(last_lat), 32'(W + 1));
`endif
                end
            end
            if (res_valid && res_ready && sb.size() != 0) begin
                e = sb.pop_front();
                check("res_prod", 32'(res_prod), 32'(e.prod));
                check("res_id", 32'(res_id), 32'(e.id));
            end
            if (res_valid) valid_seen++;
            prev_valid = res_valid;
        end else begin
            prev_valid = 1'b0;
        end
    end

    task automatic set_ops(input int k, input logic [W-1:0] a, input logic [W-1:0] b);
        req_mcd[k*W +: W] = a;
        req_mlt[k*W +: W] = b;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic issue(input int k, input logic [W-1:0] a, input logic [W-1:0] b);
        bit got;
        got = 1'b0;
        set_ops(k, a, b);
        req_valid[k] = 1'b1;
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge clk);
            if (req_ready[k]) got = 1'b1;
        end
        check("grant_seen", 32'(got), 32'd1);
        check("grant_onehot", 32'(req_ready), 32'(1 << k));
        @(posedge clk);
        #1 req_valid[k] = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy) done = 1'b1;
        end
        if (!done) check("drain_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [N-1:0] gv;
        int           ng;
        int           granted;
        bit           got;

        rst_n     = 1'b0;
        req_valid = '0;
        req_mcd   = '0;
        req_mlt   = '0;
        res_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_res_prod", 32'(res_prod), 32'd0);
        check("rst_res_id", 32'(res_id), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: single request, latency and product
        res_ready = 1'b1;
        issue(0, 8'd13, 8'd11);
        drain();

        // 2: extreme operands
        issue(2, 8'hFF, 8'hFF);
        drain();
        issue(2, 8'h00, 8'hFF);
        drain();
        issue(2, 8'hFF, 8'h00);
        drain();
`ifdef MULT_EARLY_DONE_EN
        check("early_zero_latency", 32'(last_lat), 32'd2);
`endif

        // 3: fairness with all requesters valid
        apply_reset();
        grant_q.delete();
        for (int k = 0; k < N; k++) begin
            set_ops(k, 8'(10 + k * 17), 8'(3 + k * 29));
        end
        req_valid = '1;
        ng = 0;
        for (int c = 0; c < 200 && ng < 5; c++) begin
            @(negedge clk);
            gv = req_ready & req_valid;
            @(posedge clk);
            #1;
            for (int k = 0; k < N; k++) begin
                if (gv[k]) begin
                    ng++;
                    set_ops(k, 8'(40 + ng * 23), 8'(7 + ng * 31));
                end
            end
        end
        req_valid = '0;
        drain();
        check("grant_count", 32'(grant_q.size()), 32'd5);
        if (grant_q.size() >= 5) begin
            check("grant_0", 32'(grant_q[0]), 32'd0);
            check("grant_1", 32'(grant_q[1]), 32'd1);
            check("grant_2", 32'(grant_q[2]), 32'd2);
            check("grant_3", 32'(grant_q[3]), 32'd3);
            check("grant_4", 32'(grant_q[4]), 32'd0);
        end

        // 4: backpressure in DONE
        res_ready = 1'b0;
        issue(1, 8'd200, 8'd77);
        got = 1'b0;
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge clk);
            if (res_valid) got = 1'b1;
        end
        check("done_reached", 32'(got), 32'd1);
        @(posedge clk);
        #1;
        set_ops(3, 8'd9, 8'd250);
        req_valid[3] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("hold_valid", 32'(res_valid), 32'd1);
            check("hold_prod", 32'(res_prod), 32'd15400);
            check("hold_id", 32'(res_id), 32'd1);
            check("hold_no_grant", 32'(req_ready), 32'd0);
        end
        @(posedge clk);
        #1 res_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("exit_valid", 32'(res_valid), 32'd0);
        check("exit_busy", 32'(busy), 32'd0);
        check("exit_grant", 32'(req_ready), 32'b1000);
        @(posedge clk);
        #1 req_valid[3] = 1'b0;
        drain();

        // 5: reset during RUN
        issue(2, 8'd7, 8'd9);
        repeat (3) @(posedge clk);
        #1;
        set_ops(0, 8'd5, 8'd6);
        req_valid[0] = 1'b1;
        rst_n = 1'b0;
        #1;
        check("abort_res_valid", 32'(res_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_req_ready", 32'(req_ready), 32'd0);
        check("abort_res_prod", 32'(res_prod), 32'd0);
        check("abort_res_id", 32'(res_id), 32'd0);
        sb.delete();
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        valid_seen = 0;
        repeat (12) @(posedge clk);
        #1;
        check("abort_no_result", 32'(valid_seen), 32'd0);
        set_ops(3, 8'd33, 8'd44);
        req_valid[0] = 1'b1;
        req_valid[3] = 1'b1;
        @(negedge clk);
        check("post_reset_grant", 32'(req_ready), 32'b0001);
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge clk);
            if (req_ready[3]) got = 1'b1;
        end
        check("post_reset_grant3", 32'(got), 32'd1);
        @(posedge clk);
        #1 req_valid[3] = 1'b0;
        drain();

        // 6: random regression
        granted = 0;
        for (int c = 0; c < 60000 && granted < 1000; c++) begin
            @(negedge clk);
            gv = req_ready & req_valid;
            @(posedge clk);
            #1;
            for (int k = 0; k < N; k++) begin
                if (gv[k]) begin
                    req_valid[k] = 1'b0;
                    granted++;
                end
            end
            for (int k = 0; k < N; k++) begin
                if (!req_valid[k] && (granted + $countones(req_valid)) < 1000
                    && $urandom_range(0, 2) == 0) begin
                    set_ops(k, 8'($urandom), 8'($urandom));
                    req_valid[k] = 1'b1;
                end
            end
            res_ready = ($urandom_range(0, 3) != 0);
        end
        check("rand_granted", 32'(granted), 32'd1000);
        req_valid = '0;
        res_ready = 1'b1;
        drain();
        check("rand_sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
